// File: rtl/bram_sp.sv
// Single-port synchronous block RAM with registered read and selectable read-during-write mode.
// Define BRAM_OUTREG_EN to add a second output register (2-cycle read latency).
module bram_sp #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 15,
    parameter int unsigned DEPTH      = 32768,
    parameter int unsigned WRITE_MODE = 0
) (
    input  logic              clka,
    input  logic              rsta,
    input  logic              wea,
    input  logic [ADDR_W-1:0] addra,
    input  logic [DATA_W-1:0] dina,
    output logic [DATA_W-1:0] douta
);

    localparam int unsigned IDX_W         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned MODE_RD_FIRST = 0;
    localparam int unsigned MODE_WR_FIRST = 1;
    localparam int unsigned MODE_NO_CHG   = 2;
    // Out-of-range mode values degrade to read-first.
    localparam int unsigned MODE          = (WRITE_MODE > MODE_NO_CHG) ? MODE_RD_FIRST : WRITE_MODE;

    logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

    logic              in_range_c;
    logic              wr_c;
    logic [IDX_W-1:0]  idx_c;
    logic [DATA_W-1:0] rd_c;
    logic [DATA_W-1:0] q1;
    logic [DATA_W-1:0] q1_nxt_c;

    // Address decode and array read.
    always_comb begin
        in_range_c = ({1'b0, addra} < (ADDR_W + 1)'(DEPTH));
        idx_c      = addra[IDX_W-1:0];
        wr_c       = wea && in_range_c;
        rd_c       = in_range_c ? mem[idx_c] : '0;
    end

    // Array write; suppressed while reset is held.
    always_ff @(posedge clka) begin
        if (!rsta && wr_c) begin
            mem[idx_c] <= dina;
        end
    end

    // Read-during-write selection for the first output stage.
    always_comb begin
        q1_nxt_c = rd_c;
        if (wr_c) begin
            if (MODE == MODE_WR_FIRST) begin
                q1_nxt_c = dina;
            end else if (MODE == MODE_NO_CHG) begin
                q1_nxt_c = q1;
            end
        end
    end

    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            q1 <= '0;
        end else begin
            q1 <= q1_nxt_c;
        end
    end

`ifdef BRAM_OUTREG_EN
    logic [DATA_W-1:0] q2;

    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            q2 <= '0;
        end else begin
            q2 <= q1;
        end
    end

    assign douta = q2;
`else
    assign douta = q1;
`endif

endmodule

// File: tb/tb_bram_sp.sv
// Bench for bram_sp: four instances (read-first, write-first, no-change, and a
// 1000-word read-first) share one stimulus stream and are checked against an array model.
module tb_bram_sp;

`ifdef BRAM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam int SMALL = 1000;

    logic        clk = 1'b0;
    logic        rsta;
    logic        wea;
    logic [14:0] addra;
    logic [31:0] dina;
    logic [31:0] dout [4];

    int checks   = 0;
    int failures = 0;

    always #15 clk = ~clk;

    bram_sp #(.WRITE_MODE(0)) u_rf (.clka(clk), .rsta(rsta), .wea(wea), .addra(addra), .dina(dina), .douta(dout[0]));
    bram_sp #(.WRITE_MODE(1)) u_wf (.clka(clk), .rsta(rsta), .wea(wea), .addra(addra), .dina(dina), .douta(dout[1]));
    bram_sp #(.WRITE_MODE(2)) u_nc (.clka(clk), .rsta(rsta), .wea(wea), .addra(addra), .dina(dina), .douta(dout[2]));
    bram_sp #(.WRITE_MODE(0), .DEPTH(SMALL)) u_oor (.clka(clk), .rsta(rsta), .wea(wea), .addra(addra), .dina(dina), .douta(dout[3]));

    // Reference model: word arrays plus the values each instance should present.
    logic [31:0] mm [32768];
    logic [31:0] ms [SMALL];
    logic [31:0] s1 [4];
    logic [31:0] s2 [4];
    string       nm [4] = '{"rf", "wf", "nc", "oor"};

    typedef struct {
        logic        we;
        logic [14:0] addr;
        logic [31:0] din;
        logic [31:0] e [4];
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mexp(input int i);
        return (LAT == 2) ? s2[i] : s1[i];
    endfunction

    task automatic model_clk(input logic r, input logic we, input logic [14:0] a, input logic [31:0] d);
        logic [31:0] oldf;
        logic [31:0] olds;
        if (r) begin
            for (int i = 0; i < 4; i++) begin
                s1[i] = '0;
                s2[i] = '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) s2[i] = s1[i];
            oldf  = mm[a];
            olds  = (int'(a) < SMALL) ? ms[a] : 32'h0;
            s1[0] = oldf;
            s1[1] = we ? d : oldf;
            s1[2] = we ? s1[2] : oldf;
            s1[3] = olds;
            if (we) begin
                mm[a] = d;
                if (int'(a) < SMALL) ms[a] = d;
            end
        end
    endtask

    task automatic step(input logic r, input logic we, input logic [14:0] a, input logic [31:0] d);
        @(negedge clk);
        rsta  = r;
        wea   = we;
        addra = a;
        dina  = d;
        @(posedge clk);
        model_clk(r, we, a, d);
        #1;
        for (int i = 0; i < 4; i++) chk(nm[i], dout[i], mexp(i));
    endtask

    function automatic vec_t mk(input logic we, input logic [14:0] a, input logic [31:0] d,
                                input logic [31:0] rf, input logic [31:0] wf,
                                input logic [31:0] nc, input logic [31:0] oor);
        vec_t v;
        v.we = we; v.addr = a; v.din = d;
        v.e[0] = rf; v.e[1] = wf; v.e[2] = nc; v.e[3] = oor;
        return v;
    endfunction

    initial begin
        logic [14:0] ra;
        logic [31:0] e;

        for (int i = 0; i < 32768; i++) mm[i] = '0;
        for (int i = 0; i < SMALL; i++) ms[i] = '0;
        for (int i = 0; i < 4; i++) begin
            s1[i] = '0;
            s2[i] = '0;
        end

        // Stage-one read values from a fresh memory, in stream order.
        tbl[0]  = mk(1, 15'h0000, 32'h12345678, 32'h0,        32'h12345678, 32'h0,        32'h0);
        tbl[1]  = mk(1, 15'h7FFF, 32'hCAFEF00D, 32'h0,        32'hCAFEF00D, 32'h0,        32'h0);
        tbl[2]  = mk(0, 15'h0000, 32'h0,        32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678);
        tbl[3]  = mk(0, 15'h7FFF, 32'h0,        32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D, 32'h0);
        tbl[4]  = mk(1, 15'd5,    32'h11111111, 32'h0,        32'h11111111, 32'hCAFEF00D, 32'h0);
        tbl[5]  = mk(1, 15'd5,    32'h22222222, 32'h11111111, 32'h22222222, 32'hCAFEF00D, 32'h11111111);
        tbl[6]  = mk(0, 15'd5,    32'h0,        32'h22222222, 32'h22222222, 32'h22222222, 32'h22222222);
        tbl[7]  = mk(1, 15'd100,  32'hA5A5A5A5, 32'h0,        32'hA5A5A5A5, 32'h22222222, 32'h0);
        tbl[8]  = mk(0, 15'd100,  32'h0,        32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5);
        tbl[9]  = mk(0, 15'd1234, 32'h0,        32'h0,        32'h0,        32'h0,        32'h0);
        tbl[10] = mk(1, 15'd1500, 32'h0000BEEF, 32'h0,        32'h0000BEEF, 32'h0,        32'h0);
        tbl[11] = mk(0, 15'd1500, 32'h0,        32'h0000BEEF, 32'h0000BEEF, 32'h0000BEEF, 32'h0);
        tbl[12] = mk(0, 15'h0000, 32'h0,        32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678);
        tbl[13] = mk(0, 15'd476,  32'h0,        32'h0,        32'h0,        32'h0,        32'h0);

        // Power-up reset held for 100 ns; output must stay 0.
        rsta = 1'b1; wea = 1'b0; addra = '0; dina = '0;
        for (int t = 0; t < 10; t++) begin
            #10;
            for (int i = 0; i < 4; i++) chk({"rst_hold_", nm[i]}, dout[i], 32'h0);
        end

        // Directed table, expectations shifted by the output latency.
        for (int k = 0; k < 14; k++) begin
            step(0, tbl[k].we, tbl[k].addr, tbl[k].din);
            for (int i = 0; i < 4; i++) begin
                e = (k >= LAT - 1) ? tbl[k - LAT + 1].e[i] : 32'h0;
                chk({"tbl_", nm[i]}, dout[i], e);
            end
        end

        // Asynchronous reset mid-cycle while douta shows DEADBEEF.
        step(0, 1, 15'd7, 32'hDEADBEEF);
        for (int k = 0; k < LAT; k++) step(0, 0, 15'd7, 32'h0);
        chk("pre_async_rf", dout[0], 32'hDEADBEEF);
        #5 rsta = 1'b1;
        #1;
        model_clk(1, 0, '0, '0);
        for (int i = 0; i < 4; i++) chk({"async_rst_", nm[i]}, dout[i], 32'h0);

        // Write attempted while reset is held must not land.
        step(1, 1, 15'd100, 32'hFFFFFFFF);
        for (int k = 0; k < LAT; k++) step(0, 0, 15'd100, 32'h0);
        chk("rst_keeps_mem", dout[0], 32'hA5A5A5A5);

        // Sweep low and high ends of the array, then untouched words.
        for (int i = 0; i < 1024; i++) step(0, 1, 15'(i), 32'(i * 3));
        for (int i = 31744; i < 32768; i++) step(0, 1, 15'(i), 32'(i * 3));
        for (int i = 0; i < 1024; i++) step(0, 0, 15'(i), 32'h0);
        for (int i = 31744; i < 32768; i++) step(0, 0, 15'(i), 32'h0);
        for (int i = 2000; i < 2032; i++) step(0, 0, 15'(i), 32'h0);

        // Random traffic with occasional reset pulses.
        for (int n = 0; n < 3000; n++) begin
            case ($urandom_range(0, 2))
                0:       ra = 15'($urandom_range(0, 63));
                1:       ra = 15'($urandom_range(990, 1010));
                default: ra = 15'($urandom);
            endcase
            step(($urandom_range(0, 99) == 0), 1'($urandom), ra, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog so the bench always terminates.
    initial begin
        #5ms;
        failures++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
